fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 145 ++++++++++++++
 tb/tb_fetch_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem read, IF/ID output register, redirect/drain handling.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int                 width    = 32,
  parameter logic [width-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               start,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [width-1:0]   redirect_pc,
  output logic               imem_req,
  output logic [width-1:0]   imem_addr,
  input  logic               imem_valid,
  input  logic [width-1:0]   imem_rdata,
  output logic [width-1:0]   inst_out,
  output logic [width-1:0]   pc_out,
  output logic               valid_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  localparam logic [width-1:0] NOP  = width'(32'h0000_0013);
  localparam logic [width-1:0] STEP = width'(4);

  logic [1:0]       state, state_nx;
  logic [width-1:0] pc, pc_nx;
  logic [width-1:0] drain_addr, drain_addr_nx;
  logic [width-1:0] buf_inst, buf_inst_nx;
  logic             load;
  logic [width-1:0] load_inst;
  logic             flush;

  // Request side: DRAIN keeps presenting the abandoned address until its response arrives.
  assign imem_req  = (state == WAIT) || (state == DRAIN);
  assign imem_addr = (state == DRAIN) ? drain_addr : pc;

  // Redirect in IDLE only retargets pc; the outputs already hold a bubble there.
  assign flush = redirect_valid && (state != IDLE);

  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    drain_addr_nx = drain_addr;
    buf_inst_nx   = buf_inst;
    load          = 1'b0;
    load_inst     = imem_rdata;
    case (state)
      IDLE: begin
        state_nx = WAIT;
        if (redirect_valid) pc_nx = redirect_pc;
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nx = redirect_pc;
          if (!imem_valid) begin
            drain_addr_nx = pc;
            state_nx      = DRAIN;
          end
        end else if (imem_valid) begin
          if (stall) begin
            buf_inst_nx = imem_rdata;
            state_nx    = HOLD;
          end else begin
            load      = 1'b1;
            load_inst = imem_rdata;
            pc_nx     = pc + STEP;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nx    = redirect_pc;
          state_nx = WAIT;
        end else if (!stall) begin
          load      = 1'b1;
          load_inst = buf_inst;
          pc_nx     = pc + STEP;
          state_nx  = WAIT;
        end
      end
      DRAIN: begin
        if (redirect_valid) pc_nx = redirect_pc;
        // A response arriving with a new redirect is still the stale one; leaving avoids waiting forever.
        if (imem_valid) state_nx = WAIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control and pc register
  always_ff @(posedge clk) begin
    if (!start) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drain_addr <= '0;
      buf_inst   <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      drain_addr <= drain_addr_nx;
      buf_inst   <= buf_inst_nx;
    end
  end

  // IF/ID output register
  always_ff @(posedge clk) begin
    if (!start) begin
      inst_out  <= NOP;
      pc_out    <= '0;
      valid_out <= 1'b0;
    end else if (flush) begin
      inst_out  <= NOP;
      valid_out <= 1'b0;
    end else if (load) begin
      inst_out  <= load_inst;
      pc_out    <= pc;
      valid_out <= 1'b1;
    end else if (!stall) begin
      inst_out  <= NOP;
      valid_out <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!start) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (load)           perf_fetched <= perf_fetched + 32'd1;
      if (!load && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-driven imem handshakes, stalls, redirects and pc wrap.
module tb_fetch_stage;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic        clk = 1'b0;
  logic        start, stall, redirect_valid, imem_valid;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, valid_out;
  logic [31:0] imem_addr, inst_out, pc_out;
  logic        w_req, w_valid_out;
  logic [31:0] w_addr, w_inst, w_pc_out;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, w_pf, w_pb;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(.width(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst_out(inst_out), .pc_out(pc_out), .valid_out(valid_out)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  fetch_stage #(.width(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .start(start), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .inst_out(w_inst), .pc_out(w_pc_out), .valid_out(w_valid_out)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(w_pf), .perf_bubbles(w_pb)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] inst, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({tag, ".inst"}, inst_out, inst);
    chk({tag, ".pc"}, pc_out, pc);
  endtask

  initial begin
    start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    step(); step();
    chk_out("reset", 1'b0, 32'h13, 32'h0);
    chk("reset.req", {31'd0, imem_req}, 32'd0);
    chk("reset.state", {30'd0, dut.state}, {30'd0, S_IDLE});

    // Release: first request at 0x0, wrap instance at 0xFFFFFFFC
    start = 1'b1;
    step();
    chk("rel.req", {31'd0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'h0);
    chk("wrap.addr0", w_addr, 32'hFFFF_FFFC);

    imem_valid = 1'b1; imem_rdata = 32'hA0;
    step();
    chk_out("f0", 1'b1, 32'hA0, 32'h0);
    chk("f0.addr", imem_addr, 32'h4);
    chk("wrap.pc_out", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap.addr1", w_addr, 32'h0);
    imem_valid = 1'b0;
    step();
    chk_out("b0", 1'b0, 32'h13, 32'h0);
    chk("b0.addr", imem_addr, 32'h4);
    imem_valid = 1'b1; imem_rdata = 32'hA1;
    step();
    chk_out("f1", 1'b1, 32'hA1, 32'h4);
    chk("f1.addr", imem_addr, 32'h8);
    imem_valid = 1'b0;
    step();
    chk_out("b1", 1'b0, 32'h13, 32'h4);
    imem_valid = 1'b1; imem_rdata = 32'hA2;
    step();
    chk_out("f2", 1'b1, 32'hA2, 32'h8);
    chk("f2.addr", imem_addr, 32'hC);
    imem_valid = 1'b0;
    step();
    chk_out("b2", 1'b0, 32'h13, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    chk("perf.fetched", perf_fetched, 32'd3);
`endif

    // Mid-run reset
    start = 1'b0;
    step();
    chk("rst2.state", {30'd0, dut.state}, {30'd0, S_IDLE});
    chk_out("rst2", 1'b0, 32'h13, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2.fetched", perf_fetched, 32'd0);
    chk("rst2.bubbles", perf_bubbles, 32'd0);
`endif

    // Stall while 0xA1 @0x4 returns
    start = 1'b1;
    step();
    imem_valid = 1'b1; imem_rdata = 32'hA0;
    step();
    imem_valid = 1'b0;
    step();
    chk("s.addr", imem_addr, 32'h4);
    stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hA1;
    step();
    chk("s.state", {30'd0, dut.state}, {30'd0, S_HOLD});
    chk("s.req", {31'd0, imem_req}, 32'd0);
    chk_out("s1", 1'b0, 32'h13, 32'h0);
    imem_rdata = 32'hDEAD;
    step();
    chk_out("s2", 1'b0, 32'h13, 32'h0);
    step();
    chk_out("s3", 1'b0, 32'h13, 32'h0);
    chk("s3.state", {30'd0, dut.state}, {30'd0, S_HOLD});
    stall = 1'b0; imem_valid = 1'b0;
    step();
    chk_out("unstall", 1'b1, 32'hA1, 32'h4);
    chk("unstall.addr", imem_addr, 32'h8);
    chk("unstall.req", {31'd0, imem_req}, 32'd1);
    stall = 1'b1;
    step();
    chk_out("holdv", 1'b1, 32'hA1, 32'h4);
    stall = 1'b0;

    // Redirect to 0x100 while 0x8 is outstanding
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    chk("d.state", {30'd0, dut.state}, {30'd0, S_DRAIN});
    chk("d.addr", imem_addr, 32'h8);
    chk("d.req", {31'd0, imem_req}, 32'd1);
    chk_out("d", 1'b0, 32'h13, 32'h4);
    redirect_valid = 1'b0;
    step();
    chk("d2.addr", imem_addr, 32'h8);
    imem_valid = 1'b1; imem_rdata = 32'hBAD8;
    step();
    chk_out("d3", 1'b0, 32'h13, 32'h4);
    chk("d3.state", {30'd0, dut.state}, {30'd0, S_WAIT});
    chk("d3.addr", imem_addr, 32'h100);

    // Redirect beats stall and imem_valid
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    imem_valid = 1'b1; imem_rdata = 32'hC100;
    step();
    chk_out("pri", 1'b0, 32'h13, 32'h4);
    chk("pri.addr", imem_addr, 32'h40);
    chk("pri.state", {30'd0, dut.state}, {30'd0, S_WAIT});
    redirect_valid = 1'b0; stall = 1'b0; imem_rdata = 32'hE0;
    step();
    chk_out("pri.f", 1'b1, 32'hE0, 32'h40);
    chk("pri.addr2", imem_addr, 32'h44);

    // Redirect in IDLE only moves pc
    imem_valid = 1'b0; start = 1'b0;
    step();
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    chk("idle.addr", imem_addr, 32'h200);
    chk_out("idle", 1'b0, 32'h13, 32'h0);

    // Redirect in HOLD drops the buffer
    redirect_valid = 1'b0; stall = 1'b1; imem_valid = 1'b1; imem_rdata = 32'hF0;
    step();
    chk("h.state", {30'd0, dut.state}, {30'd0, S_HOLD});
    redirect_valid = 1'b1; redirect_pc = 32'h300; imem_valid = 1'b0;
    step();
    chk("h.addr", imem_addr, 32'h300);
    chk("h.state2", {30'd0, dut.state}, {30'd0, S_WAIT});
    redirect_valid = 1'b0; stall = 1'b0; imem_valid = 1'b1; imem_rdata = 32'hF1;
    step();
    chk_out("h.f", 1'b1, 32'hF1, 32'h300);
    imem_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
